lifo_stack: RTL
===============

# lifo_stack

Hardware LIFO that serves as the data stack for the multicycle stack processor. It is the responder side of the processor's push/pop interface. It holds up to DEPTH words and presents the current top of stack combinationally, so a pop asserted in one cycle returns valid data in that same cycle. It reports full/empty status and sticky overflow/underflow errors, and provides a debug peek port and a high-watermark counter for the bench and the board LEDs.

## Interface
Parameters:
- WIDTH, 8: data word width.
- ADDR_W, 4: pointer width. DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetN  input  1  reset, synchronous, active-low.
- push  input  1  write data_in onto the stack at this edge.
- pop  input  1  remove the top entry at this edge.
- data_in  input  WIDTH  word to push; sampled only when push=1.
- data_out  output  WIDTH  current top of stack, combinational from state; 0 when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  number of valid entries.
- overflow  output  1  sticky; set on push while full without pop.
- underflow  output  1  sticky; set on pop while empty.
- err_clr  input  1  clears overflow/underflow at this edge.
- peek_idx  input  ADDR_W  depth below top (0 = top).
- peek_data  output  WIDTH  entry at peek_idx; 0 if peek_idx >= count.
- max_count  output  ADDR_W+1  highest count reached since reset.

## Operation
- Storage: DEPTH x WIDTH register array mem. Stack pointer sp equals count. The top entry is mem[sp-1].
- Memory contents are not reset. Every read path is masked by count, so stale contents are never visible.
- Push only, not full: mem[sp] <= data_in; sp <= sp+1.
- Push only, full: no write, sp unchanged, overflow <= 1.
- Pop only, not empty: sp <= sp-1. data_out held the popped word during the pop cycle.
- Pop only, empty: sp unchanged, underflow <= 1, data_out stays 0.
- Push and pop together, count >= 1 (including full): replace the top. mem[sp-1] <= data_in, sp unchanged, no error flag.
- Push and pop together, empty: the push is performed (mem[0] <= data_in, sp <= 1) and underflow <= 1.
- err_clr: clears both sticky flags. If an error event occurs in the same cycle, the event wins and its flag reads 1 next cycle.
- max_count: updated to the next count whenever next count > max_count. It is unaffected by err_clr.
- peek_data = mem[sp-1-peek_idx] when peek_idx < count, else 0. Purely combinational.
- Multi-cycle pop: pop held high for N consecutive cycles removes N entries. data_out in each of those cycles shows the entry being removed at the closing edge. The processor's add/sub sequence relies on this behaviour.
- No internal FSM beyond sp and the flags. The processor owns sequencing and must not assume any handshake acknowledge.

## Timing
- Reset (resetN=0 at an edge): sp=0, overflow=0, underflow=0, max_count=0. Resulting outputs: data_out=0, empty=1, full=0, count=0, peek_data=0.
- Reset takes priority over push/pop/err_clr in the same cycle.
- Reset asserted during a multi-cycle pop sequence empties the stack immediately. Pops that follow raise underflow.
- Latency:
  - data_out, full, empty, count and peek_data reflect a push/pop in the cycle after the edge that performs it.
  - data_out is valid in the same cycle pop is high. The processor samples it at the closing edge.
- No combinational path from push/pop to any output. data_out depends only on sp and mem.
- Arithmetic: sp is ADDR_W+1 bits with range 0..DEPTH and never wraps. Writes index mem with sp[ADDR_W-1:0].

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, data_out=0x33, peek_idx=2 gives 0x11, max_count=3.
- From that state, pop held 2 cycles -> data_out=0x33 in the first pop cycle and 0x22 in the second; afterwards count=1, data_out=0x11, no error flags.
- Fill to 16 entries (DEPTH=16), then push 0xAA -> full=1, count stays 16, overflow=1, top unchanged. Then push+pop with 0x55 -> top=0x55, count=16, no new error.
- Empty stack, pop -> underflow=1, count=0, data_out=0. err_clr together with a second empty pop -> underflow remains 1. err_clr alone -> underflow=0.
- Empty stack, push+pop with data 0x7F -> count=1, data_out=0x7F, underflow=1.
- Push 0x05 and 0x03 on two cycles, pop for 2 cycles, then push 0x08 (processor add pattern) -> data_out=0x08, count=1. Assert resetN=0 with push=1 -> count=0 and max_count=0 after the edge.

Source files
------------

// File: rtl/lifo_stack.sv
// Register-array LIFO used as the stack processor's data stack.
// Top of stack and peek reads are combinational from sp and mem; all reads are masked by count.
module lifo_stack #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] peek_idx,
  output logic [WIDTH-1:0]  peek_data,
  output logic [ADDR_W:0]   max_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   sp;
  logic [ADDR_W:0]   sp_next;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] peek_pos;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              ov_set;
  logic              un_set;

  assign count   = sp;
  assign empty   = (sp == '0);
  assign full    = (sp == (ADDR_W+1)'(DEPTH));
  // Low bits wrap to DEPTH-1 when sp == DEPTH, which is the correct top slot.
  assign top_idx  = sp[ADDR_W-1:0] - ADDR_W'(1);
  assign peek_pos = top_idx - peek_idx;

  assign data_out  = empty ? '0 : mem[top_idx];
  assign peek_data = ({1'b0, peek_idx} < sp) ? mem[peek_pos] : '0;

  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_addr = sp[ADDR_W-1:0];
    ov_set  = 1'b0;
    un_set  = 1'b0;
    if (push && pop) begin
      wr_en = 1'b1;
      if (empty) begin
        sp_next = sp + (ADDR_W+1)'(1);
        un_set  = 1'b1;
      end else begin
        wr_addr = top_idx;
      end
    end else if (push) begin
      if (full) begin
        ov_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        sp_next = sp + (ADDR_W+1)'(1);
      end
    end else if (pop) begin
      if (empty) un_set = 1'b1;
      else       sp_next = sp - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && resetN) mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      max_count <= '0;
    end else begin
      sp        <= sp_next;
      overflow  <= ov_set | (overflow  & ~err_clr);
      underflow <= un_set | (underflow & ~err_clr);
      if (sp_next > max_count) max_count <= sp_next;
    end
  end

endmodule
